load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised load/store unit between the core datapath and the data-memory bus. It replaces the fixed-width, combinational byte/halfword extension and raw store-data path with a sequenced unit. The unit turns one core request of any supported size and alignment into one or two bus beats, with byte enables, lane shifting, sign/zero extension, and a request/done handshake. A load or store that is in flight stalls the core through `busy`.

## Interface
Parameters:
- `XLEN`, 32: data width, either 32 or 64; number of byte lanes NB = XLEN/8.
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 1: core request, sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 0 = byte, 1 = half, 2 = word, 3 = dword (dword is legal only when XLEN=64).
- `sext` in 1: sign-extend load result.
- `addr` in ADDR_W: byte address.
- `wdata` in XLEN: store data, right-justified.
- `rdata` out XLEN: extended load result.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: one-cycle pulse, coincident with `done`.
- `busy` out 1: high when state is not IDLE.
- `bus_req` out 1: bus request.
- `bus_we` out 1: bus write.
- `bus_addr` out ADDR_W: NB-aligned bus address (low log2(NB) bits are 0).
- `bus_be` out NB: byte enables.
- `bus_wdata` out XLEN: lane-positioned store data.
- `bus_ack` in 1: beat complete; read data is valid in the same cycle.
- `bus_rdata` in XLEN: bus read data.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - On `req`, latch `we`, `size`, `sext`, `addr`, `wdata`; offset = addr mod NB; bytes = 1<<size.
  - Illegal size (size=3 with XLEN=32) → RESP with fault.
  - Otherwise → BEAT0.
- Misaligned means offset + bytes > NB. Byte accesses are never misaligned.
- BEAT0:
  - `bus_req`=1, `bus_addr` = addr with low bits cleared.
  - `bus_be` = ((1<<bytes)-1)<<offset, truncated to NB bits.
  - `bus_wdata` = wdata << 8*offset.
  - On `bus_ack`: capture `bus_rdata`, then → BEAT1 if misaligned, else → RESP.
- BEAT1:
  - `bus_addr` = aligned address + NB, wrapping modulo 2^ADDR_W.
  - `bus_be` = (1<<(offset+bytes-NB))-1.
  - `bus_wdata` = wdata >> 8*(NB-offset).
  - On `bus_ack` → RESP.
- RESP:
  - `done`=1 for one cycle, then → IDLE.
- Load assembly: raw = (beat0 >> 8*offset) | (beat1 << 8*(NB-offset)). Keep the low 8*bytes bits, then sign-extend (`sext`=1) or zero-extend to XLEN.
- `rdata` is registered. It holds its value until the next load's RESP.
- Stores leave `rdata` unchanged. A faulting access drives `rdata` = 0.
- `req` is ignored while `busy`=1. The core holds its request until `done`.
- While `bus_req` is high, `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` are stable until `bus_ack`.

## Timing
- Reset values: state IDLE; `rdata`, `done`, `fault`, `busy`, `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata` all 0.
- All outputs are registered or decoded from state only. There is no combinational path from `req` or `bus_ack` to any output.
- Cycle 0: `req` is sampled. Cycle 1: `bus_req` rises.
- Aligned access with `bus_ack` in cycle k: `done` in cycle k+1. With zero-wait ack (k=1), total latency is 2 cycles.
- Split access: BEAT1 `bus_req` is asserted in the cycle after the BEAT0 ack. `done` comes one cycle after the BEAT1 ack. Zero-wait latency is 3 cycles.
- Fault: `done`=`fault`=1 in cycle 1, with no bus activity.
- A new `req` is accepted in the cycle after `done`, so the minimum request spacing is 3 cycles.
- Reset asserted mid-transaction: `bus_req` and `done` drop immediately and asynchronously; the pending access is abandoned. A late `bus_ack` arriving after reset is ignored.

## Configuration
- `LSU_MISALIGN_SPLIT_EN`, defined: misaligned accesses are split into two beats as described above.
- Not defined:
  - A misaligned access goes IDLE → RESP with `fault`=1 and `rdata`=0.
  - No bus cycle is issued.
  - The BEAT1 state and its logic are absent.
- Illegal size always faults, regardless of the macro.

## Test plan
- Aligned word load, XLEN=32, addr=0x100, bus_rdata=0x8000_00FF, zero-wait ack → bus_be=4'b1111, `done` in cycle 2, `rdata`=0x8000_00FF.
- Byte load with sext=1, addr=0x103, bus_rdata=0x80xx_xxxx → bus_be=4'b1000, `rdata`=0xFFFF_FF80. Same access with sext=0 → `rdata`=0x0000_0080.
- Half store, addr=0x102, wdata=0x0000_BEEF → bus_be=4'b1100, bus_wdata=0xBEEF_0000. `rdata` is unchanged.
- Misaligned word load at addr=0x0FE; beat0 returns 0x1122_3344 and beat1 returns 0x5566_7788.
  - Macro defined: beat1 bus_addr=0x100, bus_be=4'b0011, `rdata`=0x7788_1122, `done` in cycle 3.
  - Macro undefined: `fault`=`done`=1 in cycle 1, with no `bus_req`.
- XLEN=64, size=3 at addr=0x0 → bus_be=8'hFF. Same request with XLEN=32 → fault in cycle 1.
- `rst` pulled low while waiting for `bus_ack` in BEAT0 → `bus_req`=0 immediately. After release, the FSM is in IDLE, the late ack is ignored, and a new `req` is accepted normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: maps a core load/store of any size/alignment onto one or two XLEN-wide bus beats; `LSU_MISALIGN_SPLIT_EN enables two-beat misaligned accesses.
// Latency: req sampled -> done 2 cycles (aligned, zero-wait), 3 cycles (split); illegal or unsplittable access faults after 1 cycle.
// Backpressure: busy stalls the core until done; each bus beat holds its request, address, enables and data until bus_ack.
module load_store_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata,
    output logic              done,
    output logic              fault,
    output logic              busy,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, RESP = 2'd3} state_t;
`endif

    state_t            state_q, state_d;
    logic              we_q, sext_q, fault_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q, base_addr;
    logic [XLEN-1:0]   wdata_q, rdata_q, raw;
    logic [OW-1:0]     in_off, off_q;
    logic [OW+2:0]     off8;
    logic              in_legal, in_misal, acc_fault;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic              misal_q;
    logic [XLEN-1:0]   beat0_q;
`endif

    assign in_off   = addr[OW-1:0];
    assign in_legal = (size != 2'd3) || (XLEN == 64);
    assign in_misal = (32'(in_off) + (32'd1 << size)) > 32'(NB);
`ifdef LSU_MISALIGN_SPLIT_EN
    assign acc_fault = !in_legal;
`else
    assign acc_fault = !in_legal || in_misal;
`endif

    assign off_q     = addr_q[OW-1:0];
    assign off8      = {off_q, 3'b000};
    assign base_addr = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

    // Keep the low 8<<sz bits of v and fill the rest with zero or the top kept bit.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input logic [1:0] sz,
                                               input logic sx);
        logic [XLEN-1:0] r;
        int              nbits;
        logic            sign;
        nbits = 8 << sz;
        if (nbits > XLEN) nbits = XLEN;
        sign = sx & v[nbits-1];
        for (int i = 0; i < XLEN; i++) r[i] = (i < nbits) ? v[i] : sign;
        return r;
    endfunction

    always_comb begin
        raw = bus_rdata >> off8;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_q == BEAT1) raw = (beat0_q >> off8) | (bus_rdata << (32'(XLEN) - 32'(off8)));
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req) state_d = acc_fault ? RESP : BEAT0;
            BEAT0: if (bus_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                state_d = misal_q ? BEAT1 : RESP;
`else
                state_d = RESP;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            BEAT1: if (bus_ack) state_d = RESP;
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            fault_q <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            misal_q <= 1'b0;
            beat0_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                we_q    <= we;
                sext_q  <= sext;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
                fault_q <= acc_fault;
`ifdef LSU_MISALIGN_SPLIT_EN
                misal_q <= in_misal;
`endif
                if (acc_fault) rdata_q <= '0;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_q == BEAT0 && bus_ack) beat0_q <= bus_rdata;
`endif
            // Load result lands on the final ack so it is already valid while done is high.
            if (state_d == RESP && state_q != IDLE && !we_q) rdata_q <= extend(raw, size_q, sext_q);
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == RESP);
    assign fault = done & fault_q;
    assign rdata = rdata_q;

    always_comb begin
        bus_req   = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        if (state_q == BEAT0) begin
            bus_req   = 1'b1;
            bus_addr  = base_addr;
            bus_be    = NB'(((32'd1 << (32'd1 << size_q)) - 32'd1) << off_q);
            bus_wdata = wdata_q << off8;
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_q == BEAT1) begin
            bus_req   = 1'b1;
            bus_addr  = base_addr + ADDR_W'(NB);
            bus_be    = NB'((((32'd1 << (32'd1 << size_q)) - 32'd1) << off_q) >> NB);
            bus_wdata = wdata_q >> (32'(XLEN) - 32'(off8));
        end
`endif
    end

    assign bus_we = bus_req & we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 32-bit instance for most scenarios, 64-bit instance for dword access.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req, we, sext, done, fault, busy, bus_req, bus_we, bus_ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    logic        req64, we64, sext64, done64, fault64, busy64, bus_req64, bus_we64, bus_ack64;
    logic [1:0]  size64;
    logic [31:0] addr64, bus_addr64;
    logic [63:0] wdata64, rdata64, bus_wdata64, bus_rdata64;
    logic [7:0]  bus_be64;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.XLEN(32), .ADDR_W(32)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext), .addr(addr),
        .wdata(wdata), .rdata(rdata), .done(done), .fault(fault), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .req(req64), .we(we64), .size(size64), .sext(sext64), .addr(addr64),
        .wdata(wdata64), .rdata(rdata64), .done(done64), .fault(fault64), .busy(busy64),
        .bus_req(bus_req64), .bus_we(bus_we64), .bus_addr(bus_addr64), .bus_be(bus_be64),
        .bus_wdata(bus_wdata64), .bus_ack(bus_ack64), .bus_rdata(bus_rdata64)
    );

    // Observations from the most recent access on the 32-bit instance.
    int          done_cyc, nbeats;
    logic        obs_fault, seen_req, stable_err;
    logic [31:0] obs_rdata;
    logic [31:0] b_addr [2];
    logic [3:0]  b_be   [2];
    logic [31:0] b_wd   [2];
    logic        b_we   [2];

    // Drives one request and plays a memory that acks beat0 after wait0 idle cycles and beat1 at once.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd0, input logic [31:0] rd1,
                             input int wait0);
        int          waitc;
        logic        have_first;
        logic [67:0] first_bus;
        done_cyc = -1; nbeats = 0; obs_fault = 1'b0; obs_rdata = '0;
        seen_req = 1'b0; stable_err = 1'b0; waitc = 0; have_first = 1'b0; first_bus = '0;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
        for (int n = 1; n <= 20 && done_cyc < 0; n++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req) begin
                seen_req = 1'b1;
                if (!have_first) begin
                    first_bus  = {bus_addr, bus_be, bus_wdata};
                    have_first = 1'b1;
                end else if ({bus_addr, bus_be, bus_wdata} !== first_bus) begin
                    stable_err = 1'b1;
                end
                if (nbeats == 0 && waitc < wait0) begin
                    waitc++;
                end else begin
                    if (nbeats < 2) begin
                        b_addr[nbeats] = bus_addr; b_be[nbeats] = bus_be;
                        b_wd[nbeats] = bus_wdata; b_we[nbeats] = bus_we;
                    end
                    bus_ack    = 1'b1;
                    bus_rdata  = (nbeats == 0) ? rd0 : rd1;
                    nbeats++;
                    have_first = 1'b0;
                end
            end
            if (done) begin
                done_cyc  = n;
                obs_fault = fault;
                obs_rdata = rdata;
                req       = 1'b0;
            end
        end
        bus_ack = 1'b0;
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if ({done, fault, busy, bus_req, bus_we} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got %b exp 00000", {done, fault, busy, bus_req, bus_we}); end
        checks++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin
            failures++; $display("FAIL reset_bus got %h exp 0", {bus_addr, bus_be, bus_wdata}); end
        checks++; if ({done64, busy64, bus_req64, bus_be64} !== 11'h0) begin
            failures++; $display("FAIL reset_dut64 got %h exp 0", {done64, busy64, bus_req64, bus_be64}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_load();
        do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h8000_00FF, 32'h0, 0);
        checks++; if (done_cyc !== 2) begin failures++; $display("FAIL word_done_cycle got %0d exp 2", done_cyc); end
        checks++; if (b_be[0] !== 4'b1111) begin failures++; $display("FAIL word_be got %b exp 1111", b_be[0]); end
        checks++; if (b_addr[0] !== 32'h100) begin failures++; $display("FAIL word_addr got %h exp 100", b_addr[0]); end
        checks++; if (obs_rdata !== 32'h8000_00FF) begin failures++; $display("FAIL word_rdata got %h exp 800000ff", obs_rdata); end
        checks++; if ({obs_fault, nbeats[1:0], b_we[0]} !== 4'b0010) begin
            failures++; $display("FAIL word_fault_beats_we got %b exp 0010", {obs_fault, nbeats[1:0], b_we[0]}); end
    endtask

    task automatic test_byte_load();
        do_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0);
        checks++; if (b_be[0] !== 4'b1000) begin failures++; $display("FAIL byte_be got %b exp 1000", b_be[0]); end
        checks++; if (obs_rdata !== 32'hFFFF_FF80) begin failures++; $display("FAIL byte_sext got %h exp ffffff80", obs_rdata); end
        do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 32'h0, 0);
        checks++; if (obs_rdata !== 32'h0000_0080) begin failures++; $display("FAIL byte_zext got %h exp 00000080", obs_rdata); end
    endtask

    task automatic test_half_store();
        do_access(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF, 32'h5555_5555, 32'h0, 0);
        checks++; if (b_be[0] !== 4'b1100) begin failures++; $display("FAIL hstore_be got %b exp 1100", b_be[0]); end
        checks++; if (b_wd[0] !== 32'hBEEF_0000) begin failures++; $display("FAIL hstore_wdata got %h exp beef0000", b_wd[0]); end
        checks++; if (b_we[0] !== 1'b1) begin failures++; $display("FAIL hstore_we got %b exp 1", b_we[0]); end
        checks++; if (obs_rdata !== 32'h0000_0080) begin failures++; $display("FAIL hstore_rdata_kept got %h exp 00000080", obs_rdata); end
        checks++; if (done_cyc !== 2) begin failures++; $display("FAIL hstore_done_cycle got %0d exp 2", done_cyc); end
    endtask

    task automatic test_misaligned();
        do_access(1'b0, 2'd2, 1'b0, 32'h0FE, 32'h0, 32'h1122_3344, 32'h5566_7788, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        checks++; if (done_cyc !== 3) begin failures++; $display("FAIL mis_done_cycle got %0d exp 3", done_cyc); end
        checks++; if ({b_addr[0], b_be[0]} !== {32'h0FC, 4'b1100}) begin
            failures++; $display("FAIL mis_beat0 got %h/%b exp 000000fc/1100", b_addr[0], b_be[0]); end
        checks++; if ({b_addr[1], b_be[1]} !== {32'h100, 4'b0011}) begin
            failures++; $display("FAIL mis_beat1 got %h/%b exp 00000100/0011", b_addr[1], b_be[1]); end
        checks++; if (obs_rdata !== 32'h7788_1122) begin failures++; $display("FAIL mis_rdata got %h exp 77881122", obs_rdata); end
        do_access(1'b1, 2'd1, 1'b0, 32'h0FF, 32'h0000_A1B2, 32'h0, 32'h0, 0);
        checks++; if ({b_be[0], b_wd[0]} !== {4'b1000, 32'hB200_0000}) begin
            failures++; $display("FAIL mis_store_beat0 got %b/%h exp 1000/b2000000", b_be[0], b_wd[0]); end
        checks++; if ({b_addr[1], b_be[1], b_wd[1]} !== {32'h100, 4'b0001, 32'h0000_00A1}) begin
            failures++; $display("FAIL mis_store_beat1 got %h/%b/%h exp 00000100/0001/000000a1", b_addr[1], b_be[1], b_wd[1]); end
        checks++; if (obs_rdata !== 32'h7788_1122) begin failures++; $display("FAIL mis_store_rdata_kept got %h exp 77881122", obs_rdata); end
`else
        checks++; if (done_cyc !== 1) begin failures++; $display("FAIL mis_done_cycle got %0d exp 1", done_cyc); end
        checks++; if ({obs_fault, seen_req} !== 2'b10) begin
            failures++; $display("FAIL mis_fault_nobus got %b exp 10", {obs_fault, seen_req}); end
        checks++; if (obs_rdata !== 32'h0) begin failures++; $display("FAIL mis_rdata got %h exp 0", obs_rdata); end
`endif
    endtask

    task automatic test_illegal_size();
        do_access(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 0);
        checks++; if (done_cyc !== 1) begin failures++; $display("FAIL illegal_done_cycle got %0d exp 1", done_cyc); end
        checks++; if ({obs_fault, seen_req} !== 2'b10) begin
            failures++; $display("FAIL illegal_fault_nobus got %b exp 10", {obs_fault, seen_req}); end
        checks++; if (obs_rdata !== 32'h0) begin failures++; $display("FAIL illegal_rdata got %h exp 0", obs_rdata); end
    endtask

    task automatic test_wait_states();
        do_access(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'h8001_1234, 32'h0, 2);
        checks++; if (done_cyc !== 4) begin failures++; $display("FAIL wait_done_cycle got %0d exp 4", done_cyc); end
        checks++; if (stable_err !== 1'b0) begin failures++; $display("FAIL wait_bus_stable got %b exp 0", stable_err); end
        checks++; if ({b_be[0], obs_rdata} !== {4'b1100, 32'hFFFF_8001}) begin
            failures++; $display("FAIL wait_be_rdata got %b/%h exp 1100/ffff8001", b_be[0], obs_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] rq, dn, bz;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h300; bus_rdata = 32'h1234_5678;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            rq[n] = bus_req; dn[n] = done; bz[n] = busy;
            bus_ack = bus_req;
        end
        req = 1'b0; bus_ack = 1'b0;
        checks++; if (rq !== 6'b001001) begin failures++; $display("FAIL b2b_bus_req got %b exp 001001", rq); end
        checks++; if (dn !== 6'b010010) begin failures++; $display("FAIL b2b_done got %b exp 010010", dn); end
        checks++; if (bz !== 6'b011011) begin failures++; $display("FAIL b2b_busy got %b exp 011011", bz); end
        checks++; if (rdata !== 32'h1234_5678) begin failures++; $display("FAIL b2b_rdata got %h exp 12345678", rdata); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h400;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL rstmid_pre_req got %b exp 1", bus_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({bus_req, busy, done} !== 3'b000) begin
            failures++; $display("FAIL rstmid_async_drop got %b exp 000", {bus_req, busy, done}); end
        @(negedge clk);
        req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; rst = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        checks++; if ({bus_req, busy, done, rdata} !== {3'b000, 32'h0}) begin
            failures++; $display("FAIL rstmid_late_ack got %b/%h exp 000/0", {bus_req, busy, done}, rdata); end
        do_access(1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 32'hCAFE_F00D, 32'h0, 0);
        checks++; if ({done_cyc[3:0], obs_rdata} !== {4'd2, 32'hCAFE_F00D}) begin
            failures++; $display("FAIL rstmid_after got %0d/%h exp 2/cafef00d", done_cyc, obs_rdata); end
    endtask

    task automatic test_dword64();
        @(negedge clk);
        req64 = 1'b1; we64 = 1'b0; size64 = 2'd3; sext64 = 1'b0; addr64 = 32'h0;
        @(negedge clk);
        checks++; if ({bus_req64, bus_be64, bus_addr64} !== {1'b1, 8'hFF, 32'h0}) begin
            failures++; $display("FAIL dword_beat got %b/%h/%h exp 1/ff/0", bus_req64, bus_be64, bus_addr64); end
        bus_ack64 = 1'b1; bus_rdata64 = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        bus_ack64 = 1'b0; req64 = 1'b0;
        checks++; if ({done64, fault64, rdata64} !== {2'b10, 64'h0123_4567_89AB_CDEF}) begin
            failures++; $display("FAIL dword_result got %b/%h exp 10/0123456789abcdef", {done64, fault64}, rdata64); end
    endtask

    initial begin
        req = 0; we = 0; size = 0; sext = 0; addr = 0; wdata = 0; bus_ack = 0; bus_rdata = 0;
        req64 = 0; we64 = 0; size64 = 0; sext64 = 0; addr64 = 0; wdata64 = 0; bus_ack64 = 0; bus_rdata64 = 0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_illegal_size();
        test_wait_states();
        test_back_to_back();
        test_reset_mid();
        test_dword64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
